// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the two-master Wishbone arbiter.
//   arb_state_t   : arbiter FSM state encoding
//   TIMEOUT_CNT_W : width of the optional watchdog counter
// Bus widths come from the `ADDR_SIZE / `WORD_SIZE macros. When no project
// defines file has set them, they fall back to 32 bits here.

`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package wb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BUSY_INT  = 2'd1,
      BUSY_CORE = 2'd2
   } arb_state_t;

   localparam int TIMEOUT_CNT_W = 16;

endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: bus-cycle watchdog for wb_rr_arbiter. It is only
// instantiated when WB_ARB_TIMEOUT_EN is defined.
//   Clk     in  system clock
//   Rst     in  synchronous active-high reset
//   busy    in  arbiter is in a BUSY state
//   ack     in  slave ack for the current cycle
//   expired out this is the last BUSY cycle allowed (count == TIMEOUT_CYCLES-1)
// The counter is held at zero while the arbiter is idle. Every BUSY cycle
// therefore starts counting from 0. The counter advances on each BUSY cycle
// that has no ack.

module wb_arb_watchdog
   import wb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic Clk,
   input  logic Rst,
   input  logic busy,
   input  logic ack,
   output logic expired
);

   localparam logic [TIMEOUT_CNT_W-1:0] LAST_CNT = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_CNT_W-1:0] cnt;

   always_ff @(posedge Clk) begin
      if (Rst || !busy) begin
         cnt <= '0;
      end else if (!ack) begin
         cnt <= cnt + TIMEOUT_CNT_W'(1);
      end
   end

   assign expired = busy && (cnt == LAST_CNT);

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master Wishbone arbiter. Master 0 is the interpreter and
// master 1 is the core. Both share a single slave bus. The grant is locked from
// the start of a bus cycle until the slave acks or the master drops cs. Every
// transfer returns through IDLE.
//
// Ports:
//   Clk, Rst                         clock, synchronous active-high reset
//   Wb_*_interpreter                 master 0 request (addr/cs/we/wdata in,
//                                    rdata/ack out)
//   Wb_*_core                        master 1 request (same shape)
//   Wb_addr/cs/we/wdata  out         slave request
//   Wb_rdata/ack         in          slave response
//   Grant_core           out         registered, 1 while in BUSY_CORE
//   Timeout_err          out         one-cycle watchdog pulse
//
// Parameters:
//   FIXED_PRIO     0 = round-robin on ties, 1 = interpreter always wins ties
//   TIMEOUT_CYCLES watchdog limit in BUSY cycles, 2..65535
//
// Optional feature: define WB_ARB_TIMEOUT_EN to enable the watchdog.
//
// state     | meaning
// ----------+----------------------------------------------
// IDLE      | no owner; slave outputs 0; arbitrate requests
// BUSY_INT  | interpreter owns the bus until ack/abort
// BUSY_CORE | core owns the bus until ack/abort

module wb_rr_arbiter
   import wb_pkg::*;
#(
   parameter int          FIXED_PRIO     = 0,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [`ADDR_SIZE-1:0] Wb_addr_interpreter,
   input  logic                  Wb_cs_interpreter,
   input  logic                  Wb_we_interpreter,
   input  logic [`WORD_SIZE-1:0] Wb_wdata_interpreter,
   output logic [`WORD_SIZE-1:0] Wb_rdata_interpreter,
   output logic                  Wb_ack_interpreter,
   input  logic [`ADDR_SIZE-1:0] Wb_addr_core,
   input  logic                  Wb_cs_core,
   input  logic                  Wb_we_core,
   input  logic [`WORD_SIZE-1:0] Wb_wdata_core,
   output logic [`WORD_SIZE-1:0] Wb_rdata_core,
   output logic                  Wb_ack_core,
   output logic [`ADDR_SIZE-1:0] Wb_addr,
   output logic                  Wb_cs,
   output logic                  Wb_we,
   output logic [`WORD_SIZE-1:0] Wb_wdata,
   input  logic [`WORD_SIZE-1:0] Wb_rdata,
   input  logic                  Wb_ack,
   output logic                  Grant_core,
   output logic                  Timeout_err
);

   arb_state_t state, state_nxt;
   logic       last_core, last_core_nxt;
   logic       expired;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_rr_arbiter: TIMEOUT_CYCLES must be within 2..65535");
   end

`ifdef WB_ARB_TIMEOUT_EN
   wb_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .Clk     (Clk),
      .Rst     (Rst),
      .busy    (state != IDLE),
      .ack     (Wb_ack),
      .expired (expired)
   );
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= IDLE;
         last_core  <= 1'b1;
         Grant_core <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_core  <= last_core_nxt;
         Grant_core <= (state_nxt == BUSY_CORE);
      end
   end

   always_comb begin
      state_nxt            = state;
      last_core_nxt        = last_core;
      Wb_addr              = '0;
      Wb_cs                = 1'b0;
      Wb_we                = 1'b0;
      Wb_wdata             = '0;
      Wb_rdata_interpreter = '0;
      Wb_ack_interpreter   = 1'b0;
      Wb_rdata_core        = '0;
      Wb_ack_core          = 1'b0;
      Timeout_err          = 1'b0;

      case (state)
         IDLE: begin
            if (Wb_cs_interpreter && Wb_cs_core) begin
               // Tie: the interpreter wins when priority is fixed or when
               // the core had the previous grant.
               if ((FIXED_PRIO != 0) || last_core) begin
                  state_nxt = BUSY_INT;
               end else begin
                  state_nxt = BUSY_CORE;
               end
            end else if (Wb_cs_interpreter) begin
               state_nxt = BUSY_INT;
            end else if (Wb_cs_core) begin
               state_nxt = BUSY_CORE;
            end
         end

         BUSY_INT: begin
            Wb_addr              = Wb_addr_interpreter;
            Wb_cs                = Wb_cs_interpreter;
            Wb_we                = Wb_we_interpreter;
            Wb_wdata             = Wb_wdata_interpreter;
            Wb_rdata_interpreter = Wb_rdata;
            Wb_ack_interpreter   = Wb_ack && Wb_cs_interpreter;
            if (!Wb_cs_interpreter || Wb_ack) begin
               state_nxt     = IDLE;
               last_core_nxt = 1'b0;
            end else if (expired) begin
               Wb_cs                = 1'b0;
               Wb_ack_interpreter   = 1'b1;
               Wb_rdata_interpreter = '1;
               Timeout_err          = 1'b1;
               state_nxt            = IDLE;
               last_core_nxt        = 1'b0;
            end
         end

         BUSY_CORE: begin
            Wb_addr       = Wb_addr_core;
            Wb_cs         = Wb_cs_core;
            Wb_we         = Wb_we_core;
            Wb_wdata      = Wb_wdata_core;
            Wb_rdata_core = Wb_rdata;
            Wb_ack_core   = Wb_ack && Wb_cs_core;
            if (!Wb_cs_core || Wb_ack) begin
               state_nxt     = IDLE;
               last_core_nxt = 1'b1;
            end else if (expired) begin
               Wb_cs         = 1'b0;
               Wb_ack_core   = 1'b1;
               Wb_rdata_core = '1;
               Timeout_err   = 1'b1;
               state_nxt     = IDLE;
               last_core_nxt = 1'b1;
            end
         end

         default: state_nxt = IDLE;
      endcase

      // While reset is asserted, the in-flight transfer is dropped. A slave
      // ack that arrives in that cycle must not reach either master.
      if (Rst) begin
         Wb_addr              = '0;
         Wb_cs                = 1'b0;
         Wb_we                = 1'b0;
         Wb_wdata             = '0;
         Wb_rdata_interpreter = '0;
         Wb_ack_interpreter   = 1'b0;
         Wb_rdata_core        = '0;
         Wb_ack_core          = 1'b0;
         Timeout_err          = 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed bench for wb_rr_arbiter. Two instances share the
// same master stimulus: instance 0 uses round-robin and instance 1 uses fixed
// priority. Each instance has its own small slave that acks after a
// programmable number of cs cycles. A transaction-level model of each arbiter
// is compared against the DUT on every negedge. Hand-computed literals pin the
// key behaviours.

module tb_wb_rr_arbiter;

   localparam int AW = `ADDR_SIZE;
   localparam int WW = `WORD_SIZE;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] addr_i = '0, addr_c = '0;
   logic          cs_i = 1'b0, cs_c = 1'b0, we_i = 1'b0, we_c = 1'b0;
   logic [WW-1:0] wdata_i = '0, wdata_c = '0;
   logic [WW-1:0] s_rdata = '0;
   int            s_lat = 1;
   logic          s_en = 1'b0;
   logic          s_force = 1'b0;

   logic [WW-1:0] rd_i [2];
   logic [WW-1:0] rd_c [2];
   logic [WW-1:0] wdat [2];
   logic [AW-1:0] adr  [2];
   logic          ack_i [2];
   logic          ack_c [2];
   logic          cs    [2];
   logic          we    [2];
   logic          gc    [2];
   logic          terr  [2];
   logic          s_ack [2];
   logic [7:0]    scnt  [2];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      wb_rr_arbiter #(
         .FIXED_PRIO     (g),
         .TIMEOUT_CYCLES (TO)
      ) u_dut (
         .Clk                  (clk),
         .Rst                  (rst),
         .Wb_addr_interpreter  (addr_i),
         .Wb_cs_interpreter    (cs_i),
         .Wb_we_interpreter    (we_i),
         .Wb_wdata_interpreter (wdata_i),
         .Wb_rdata_interpreter (rd_i[g]),
         .Wb_ack_interpreter   (ack_i[g]),
         .Wb_addr_core         (addr_c),
         .Wb_cs_core           (cs_c),
         .Wb_we_core           (we_c),
         .Wb_wdata_core        (wdata_c),
         .Wb_rdata_core        (rd_c[g]),
         .Wb_ack_core          (ack_c[g]),
         .Wb_addr              (adr[g]),
         .Wb_cs                (cs[g]),
         .Wb_we                (we[g]),
         .Wb_wdata             (wdat[g]),
         .Wb_rdata             (s_rdata),
         .Wb_ack               (s_ack[g]),
         .Grant_core           (gc[g]),
         .Timeout_err          (terr[g])
      );

      // slave: ack once cs has been seen for s_lat consecutive earlier cycles
      assign s_ack[g] = s_force | (s_en && (s_lat != 0) && (scnt[g] == 8'(s_lat)));
      always @(posedge clk) begin
         if (!cs[g] || s_ack[g]) scnt[g] <= 8'd0;
         else                    scnt[g] <= scnt[g] + 8'd1;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- transaction-level model ----------------
   // owner: -1 = bus free, 0 = interpreter, 1 = core
   int owner [2] = '{-1, -1};
   int prev  [2] = '{1, 1};
   int waits [2] = '{0, 0};
   bit rec_en = 1'b0;
   int gq0 [$];
   int gq1 [$];

   function automatic bit req_of(input int m);
      return (m == 0) ? cs_i : cs_c;
   endfunction

   function automatic bit is_timeout(input int d);
`ifdef WB_ARB_TIMEOUT_EN
      return (owner[d] >= 0) && req_of(owner[d]) && !s_ack[d] && (waits[d] == TO - 1);
`else
      return 1'b0;
`endif
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         for (int d = 0; d < 2; d++) begin
            if (rst) begin
               owner[d] = -1;
               prev[d]  = 1;
               waits[d] = 0;
            end else if (owner[d] < 0) begin
               waits[d] = 0;
               if (cs_i && cs_c) owner[d] = (d == 1 || prev[d] == 1) ? 0 : 1;
               else if (cs_i)    owner[d] = 0;
               else if (cs_c)    owner[d] = 1;
            end else if (!req_of(owner[d]) || s_ack[d] || is_timeout(d)) begin
               prev[d]  = owner[d];
               owner[d] = -1;
            end else begin
               waits[d] = waits[d] + 1;
            end
         end
      end
   end

   initial begin
      logic [63:0] e_adr, e_wd, e_ri, e_rc;
      logic        e_cs, e_we, e_ai, e_ac, e_te, a;
      int          m;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            e_adr = '0; e_wd = '0; e_ri = '0; e_rc = '0;
            e_cs = 0; e_we = 0; e_ai = 0; e_ac = 0; e_te = 0;
            if (!rst && owner[d] >= 0) begin
               m     = owner[d];
               e_cs  = req_of(m);
               e_we  = (m == 0) ? we_i : we_c;
               e_adr = 64'((m == 0) ? addr_i : addr_c);
               e_wd  = 64'((m == 0) ? wdata_i : wdata_c);
               a     = s_ack[d] && e_cs;
               if (m == 0) e_ri = 64'(s_rdata);
               else        e_rc = 64'(s_rdata);
               if (is_timeout(d)) begin
                  e_cs = 0;
                  a    = 1;
                  e_te = 1;
                  if (m == 0) e_ri = 64'({WW{1'b1}});
                  else        e_rc = 64'({WW{1'b1}});
               end
               if (m == 0) e_ai = a;
               else        e_ac = a;
            end
            chk($sformatf("d%0d_cs", d),    64'(cs[d]),    64'(e_cs));
            chk($sformatf("d%0d_we", d),    64'(we[d]),    64'(e_we));
            chk($sformatf("d%0d_addr", d),  64'(adr[d]),   e_adr);
            chk($sformatf("d%0d_wdata", d), 64'(wdat[d]),  e_wd);
            chk($sformatf("d%0d_ack_i", d), 64'(ack_i[d]), 64'(e_ai));
            chk($sformatf("d%0d_ack_c", d), 64'(ack_c[d]), 64'(e_ac));
            chk($sformatf("d%0d_rd_i", d),  64'(rd_i[d]),  e_ri);
            chk($sformatf("d%0d_rd_c", d),  64'(rd_c[d]),  e_rc);
            chk($sformatf("d%0d_terr", d),  64'(terr[d]),  64'(e_te));
            chk($sformatf("d%0d_grant", d), 64'(gc[d]),    64'(owner[d] == 1));
         end
         if (rec_en) begin
            if (ack_i[0]) gq0.push_back(0);
            if (ack_c[0]) gq0.push_back(1);
            if (ack_i[1]) gq1.push_back(0);
            if (ack_c[1]) gq1.push_back(1);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_reset();
      cs_i = 0; cs_c = 0; we_i = 0; we_c = 0;
      rst = 1;
      step();
      step();
      rst = 0;
   endtask

   initial begin
      int n;
      bit got;
      int exp_rr [4];
      int exp_fp [4];
      exp_rr = '{0, 1, 0, 1};
      exp_fp = '{0, 0, 0, 0};

      step();
      step();
      @(negedge clk);
      chk("rst_grant", 64'(gc[0]), 64'd0);
      chk("rst_cs", 64'(cs[0]), 64'd0);
      rst = 0;
      step();

      // slave ack while idle is not forwarded
      s_force = 1;
      @(negedge clk);
      chk("idle_ack_i", 64'(ack_i[0]), 64'd0);
      chk("idle_ack_c", 64'(ack_c[1]), 64'd0);
      step();
      s_force = 0;

      // single interpreter read
      addr_i = AW'('h10); we_i = 0; cs_i = 1;
      s_en = 1; s_lat = 2; s_rdata = WW'('hA5A5A5A5);
      @(negedge clk);
      chk("t1_cs_req_cycle", 64'(cs[0]), 64'd0);
      step();
      @(negedge clk);
      chk("t1_cs_next_cycle", 64'(cs[0]), 64'd1);
      chk("t1_addr", 64'(adr[0]), 64'h10);
      n = 1; got = 0;
      while (!got && n < 10) begin
         if (ack_i[0]) got = 1;
         else begin
            step();
            @(negedge clk);
            n++;
         end
      end
      chk("t1_ack_seen", 64'(got), 64'd1);
      chk("t1_ack_cycle", 64'(n), 64'd3);
      chk("t1_rdata", 64'(rd_i[0]), 64'hA5A5A5A5);
      chk("t1_ack_core", 64'(ack_c[0]), 64'd0);
      step();
      cs_i = 0;
      step();

      // both requesting continuously: round-robin vs fixed priority
      do_reset();
      gq0.delete(); gq1.delete();
      rec_en = 1;
      addr_i = AW'('h100); addr_c = AW'('h200); s_lat = 1;
      cs_i = 1; cs_c = 1;
      repeat (12) step();
      rec_en = 0;
      cs_i = 0; cs_c = 0;
      chk("t2_rr_count", 64'(gq0.size()), 64'd4);
      chk("t3_fp_count", 64'(gq1.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < gq0.size()) chk($sformatf("t2_rr_grant%0d", i), 64'(gq0[i]), 64'(exp_rr[i]));
         if (i < gq1.size()) chk($sformatf("t3_fp_grant%0d", i), 64'(gq1[i]), 64'(exp_fp[i]));
      end
      step();

      // core write aborted after one BUSY cycle; pending interpreter follows
      do_reset();
      addr_c = AW'('h20); wdata_c = WW'('h12345678); we_c = 1; cs_c = 1; s_lat = 10;
      step();
      addr_i = AW'('h10); we_i = 0; cs_i = 1;
      @(negedge clk);
      chk("t4_grant_core", 64'(gc[0]), 64'd1);
      chk("t4_addr", 64'(adr[0]), 64'h20);
      chk("t4_wdata", 64'(wdat[0]), 64'h12345678);
      chk("t4_we", 64'(we[0]), 64'd1);
      step();
      cs_c = 0;
      @(negedge clk);
      chk("t4_abort_ack_c", 64'(ack_c[0]), 64'd0);
      chk("t4_abort_ack_i", 64'(ack_i[0]), 64'd0);
      step();
      @(negedge clk);
      chk("t4_idle_cs", 64'(cs[0]), 64'd0);
      step();
      s_lat = 1;
      @(negedge clk);
      chk("t4_int_cs", 64'(cs[0]), 64'd1);
      chk("t4_int_addr", 64'(adr[0]), 64'h10);
      chk("t4_int_grant", 64'(gc[0]), 64'd0);
      step();
      @(negedge clk);
      chk("t4_int_ack", 64'(ack_i[0]), 64'd1);
      step();
      cs_i = 0;
      step();

      // reset during BUSY_CORE while the slave acks
      do_reset();
      addr_c = AW'('h30); we_c = 0; cs_c = 1; s_lat = 1;
      step();
      @(negedge clk);
      chk("t5_busy_grant", 64'(gc[0]), 64'd1);
      step();
      rst = 1;
      @(negedge clk);
      chk("t5_rst_ack_c", 64'(ack_c[0]), 64'd0);
      chk("t5_rst_cs", 64'(cs[0]), 64'd0);
      chk("t5_rst_rd_c", 64'(rd_c[0]), 64'd0);
      step();
      rst = 0; cs_c = 0;
      @(negedge clk);
      chk("t5_after_grant", 64'(gc[0]), 64'd0);
      chk("t5_after_ack_c", 64'(ack_c[0]), 64'd0);
      step();

`ifdef WB_ARB_TIMEOUT_EN
      // slave never acks: watchdog fires on the 8th BUSY cycle
      do_reset();
      s_en = 0;
      addr_i = AW'('h40); we_i = 0; cs_i = 1;
      for (int k = 1; k <= TO; k++) begin
         step();
         @(negedge clk);
         if (k < TO) begin
            chk($sformatf("t6_wait_ack%0d", k), 64'(ack_i[0]), 64'd0);
            chk($sformatf("t6_wait_terr%0d", k), 64'(terr[0]), 64'd0);
         end else begin
            chk("t6_to_ack", 64'(ack_i[0]), 64'd1);
            chk("t6_to_rdata", 64'(rd_i[0]), 64'hFFFFFFFF);
            chk("t6_to_terr", 64'(terr[0]), 64'd1);
            chk("t6_to_cs", 64'(cs[0]), 64'd0);
         end
      end
      step();
      cs_i = 0;
      @(negedge clk);
      chk("t6_after_terr", 64'(terr[0]), 64'd0);
      chk("t6_after_cs", 64'(cs[0]), 64'd0);
      step();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got running expected done");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Two-master Wishbone arbiter sharing the single memory/peripheral bus between the interpreter (master 0) and the core (master 1).
- Replaces a static select line with request-driven, transaction-locked arbitration plus round-robin fairness.
- Sits between the interpreter, the core and the bus slave. Grant is held from bus-cycle start until the slave acks.
- Optional watchdog terminates hung transactions.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between masters; 1 = interpreter always wins simultaneous requests.
- TIMEOUT_CYCLES, 256: watchdog limit in BUSY cycles. Used only with WB_ARB_TIMEOUT_EN. Legal range 2..65535.

Ports:
- Clk  in  1  system clock, rising edge
- Rst  in  1  synchronous, active-high reset
- Wb_addr_interpreter  in  `ADDR_SIZE  interpreter address
- Wb_cs_interpreter  in  1  interpreter request/cycle strobe
- Wb_we_interpreter  in  1  interpreter write enable
- Wb_wdata_interpreter  in  `WORD_SIZE  interpreter write data
- Wb_rdata_interpreter  out  `WORD_SIZE  read data to interpreter
- Wb_ack_interpreter  out  1  ack to interpreter
- Wb_addr_core, Wb_cs_core, Wb_we_core, Wb_wdata_core  in  (same widths)  core master request
- Wb_rdata_core  out  `WORD_SIZE  read data to core
- Wb_ack_core  out  1  ack to core
- Wb_addr  out  `ADDR_SIZE  slave address
- Wb_cs  out  1  slave strobe
- Wb_we  out  1  slave write enable
- Wb_wdata  out  `WORD_SIZE  slave write data
- Wb_rdata  in  `WORD_SIZE  slave read data
- Wb_ack  in  1  slave ack
- Grant_core  out  1  1 while the core owns the bus (BUSY_CORE)
- Timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Clock and reset: single clock Clk; reset Rst is synchronous and active-high.
- States: IDLE, BUSY_INT, BUSY_CORE. Register last_core holds the last granted master (1 = core).
- Reset state: IDLE, last_core=1 (interpreter wins the first tie). All outputs 0, Timeout_err=0, Grant_core=0.
- IDLE:
  - Slave outputs Wb_cs/Wb_we/Wb_addr/Wb_wdata all driven 0. Both master acks 0, both rdata 0.
  - Only one master requesting: grant it.
  - Both requesting, FIXED_PRIO=0: grant the master that was not last granted.
  - Both requesting, FIXED_PRIO=1: grant the interpreter.
  - Next state is BUSY_INT or BUSY_CORE. Arbitration costs exactly one cycle: the slave sees cs no earlier than the cycle after the request.
- BUSY_x:
  - Slave outputs combinationally follow granted master x.
  - Wb_rdata/Wb_ack pass combinationally to x only. The other master sees rdata=0, ack=0 and its request stays pending.
  - Wb_ack=1 while x's cs=1: transfer completes this cycle; next state IDLE; last_core updated to x.
  - x drops cs with no ack (abort): next state IDLE, last_core updated, no ack generated.
  - Back-to-back: every transaction returns through IDLE, so the minimum per-transfer cost is 1 idle cycle + slave latency. A master cannot hold the bus across transfers.
- Wb_ack while in IDLE: ignored, not forwarded.
- Rst asserted mid-transaction: next cycle is IDLE with all outputs 0. An in-flight transfer is dropped and no ack is forwarded.
- Grant_core is registered and equals (state==BUSY_CORE).

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering BUSY and increments each BUSY cycle without Wb_ack.
  - In the cycle the count equals TIMEOUT_CYCLES-1 with no Wb_ack, the arbiter:
    - drives a one-cycle ack to the granted master with rdata forced to all-ones,
    - drives Wb_cs=0 to the slave,
    - pulses Timeout_err,
    - returns to IDLE and updates last_core.
  - A real Wb_ack in that same cycle wins: normal completion, no Timeout_err.
- Undefined: no counter, Timeout_err tied 0, BUSY persists until ack or abort.

Decomposition:
- Shared package wb_pkg: arb_state_t enum {IDLE, BUSY_INT, BUSY_CORE}; TIMEOUT_CNT_W=16. Widths keep coming from defines.svh (`ADDR_SIZE, `WORD_SIZE).
- One natural sub-module, wb_arb_watchdog (counter + expiry compare), instantiated only under WB_ARB_TIMEOUT_EN.
- The FSM and output mux stay in wb_rr_arbiter.

Test Plan:
- Single interpreter read addr 0x10, slave acks 2 cycles after cs with rdata 0xA5A5A5A5 -> Wb_cs rises 1 cycle after request; Wb_ack_interpreter=1 with rdata 0xA5A5A5A5; Wb_ack_core stays 0.
- Both cs asserted from reset, FIXED_PRIO=0, each holds cs until acked -> grants alternate interpreter, core, interpreter, core; Grant_core toggles accordingly.
- Same stimulus with FIXED_PRIO=1 and the interpreter re-requesting immediately -> core starved, all 4 grants go to the interpreter.
- Core write addr 0x20 data 0x12345678; core drops cs after 1 BUSY cycle with no ack -> IDLE next cycle, no ack to either master, pending interpreter granted next.
- Rst pulsed while in BUSY_CORE, slave acks during reset -> all outputs 0, no ack forwarded, state IDLE after reset.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks an interpreter read -> on the 8th BUSY cycle Wb_ack_interpreter=1, rdata 0xFFFFFFFF, Timeout_err one-cycle pulse, then IDLE.
